// File: rtl/pipe_credit_pkg.sv
// Shared defaults and helpers for the credit-managed pipeline output FIFO.
package pipe_credit_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int DEPTH_DEF    = 16;
  localparam int PIPE_LAT_DEF = 10;
  localparam int PTR_W_DEF    = $clog2(DEPTH_DEF);

  // Pointer type for the default depth; pointers wrap naturally at DEPTH.
  typedef logic [PTR_W_DEF-1:0] ptr_t;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_credit_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module pipe_credit_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Array write; deliberately no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pipe_credit_fifo.sv
// Credit-managed output FIFO behind a fixed-latency, non-stallable pipeline.
// Credits bound stored plus in-flight results to DEPTH; the head is registered
// first-word fall-through.
module pipe_credit_fifo
  import pipe_credit_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int CNT_W    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              issue_ok_o,
  input  logic              issue_i,
  input  logic              pipe_vld_i,
  input  logic [DATA_W-1:0] pipe_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  credits_o,
  output logic              iss_err_o,
  output logic              ovf_err_o
);

  localparam int               AW   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_credits;
  logic [DATA_W-1:0] r_m_data;
  logic              r_iss_err;
  logic              r_ovf_err;

  logic              w_pop;
  logic              w_take;
  logic              w_write;
  logic              w_drop;
  logic [AW-1:0]     w_rd_next;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_pop     = (r_count != '0) & m_ready_i;
  assign w_take    = issue_i & (r_credits != '0);
  assign w_write   = pipe_vld_i & ((r_count < FULL) | w_pop);
  assign w_drop    = pipe_vld_i & (r_count == FULL) & ~w_pop;
  assign w_rd_next = r_rd_ptr + AW'(1);

  pipe_credit_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_write),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (pipe_data_i),
    .i_rd_addr (w_rd_next),
    .o_rd_data (w_ram_rdata)
  );

  // Occupancy and credit accounting; a simultaneous take and pop cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_credits <= FULL;
    end else begin
      r_count   <= r_count + CNT_W'(w_write) - CNT_W'(w_pop);
      r_credits <= r_credits + CNT_W'(w_pop) - CNT_W'(w_take);
    end
  end

  // Read and write pointers, wrapping at DEPTH by their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
    end
  end

  // Registered head: advance from RAM on pop, or bypass incoming data when the head slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data <= '0;
    end else if (w_pop && (r_count > CNT_W'(1))) begin
      r_m_data <= w_ram_rdata;
    end else if (w_write && ((r_count == '0) || w_pop)) begin
      r_m_data <= pipe_data_i;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_err <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      if (issue_i && (r_credits == '0)) begin
        r_iss_err <= 1'b1;
      end
      if (w_drop) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  // Misconfigured parameters trip this immediately in simulation.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PIPE_LAT < 0) begin : g_param_check
    assert property (@(posedge clk) 1'b0);
  end

  assign issue_ok_o = (r_credits != '0);
  assign m_valid_o  = (r_count != '0);
  assign m_data_o   = r_m_data;
  assign count_o    = r_count;
  assign credits_o  = r_credits;
  assign iss_err_o  = r_iss_err;
  assign ovf_err_o  = r_ovf_err;

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Self-checking bench for pipe_credit_fifo with a queue-based reference model.
module tb_pipe_credit_fifo;
  import pipe_credit_pkg::*;

  localparam int DW  = DATA_W_DEF;
  localparam int DEP = DEPTH_DEF;
  localparam int LAT = PIPE_LAT_DEF;
  localparam int CW  = cnt_w(DEP);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_ok_o;
  logic          issue_i = 1'b0;
  logic          pipe_vld_i = 1'b0;
  logic [DW-1:0] pipe_data_i = '0;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i = 1'b0;
  logic [CW-1:0] count_o;
  logic [CW-1:0] credits_o;
  logic          iss_err_o;
  logic          ovf_err_o;

  typedef struct {
    int            arrive;
    logic [DW-1:0] data;
  } op_t;

  op_t           inflight[$];
  logic [DW-1:0] mq[$];
  int            mCred;
  bit            mIssErr;
  bit            mOvfErr;
  bit            invOn;
  int            cyc;
  int            popCount;
  int            checks;
  int            failures;

  pipe_credit_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .PIPE_LAT (LAT),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_ok_o  (issue_ok_o),
    .issue_i     (issue_i),
    .pipe_vld_i  (pipe_vld_i),
    .pipe_data_i (pipe_data_i),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_ready_i   (m_ready_i),
    .count_o     (count_o),
    .credits_o   (credits_o),
    .iss_err_o   (iss_err_o),
    .ovf_err_o   (ovf_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    inflight.delete();
    mq.delete();
    mCred   = DEP;
    mIssErr = 1'b0;
    mOvfErr = 1'b0;
    invOn   = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_issue_ok"}, 64'(issue_ok_o), 64'(1));
    chk({tag, "_credits"},  64'(credits_o),  64'(DEP));
    chk({tag, "_count"},    64'(count_o),    64'(0));
    chk({tag, "_m_valid"},  64'(m_valid_o),  64'(0));
    chk({tag, "_m_data"},   m_data_o,        64'(0));
    chk({tag, "_iss_err"},  64'(iss_err_o),  64'(0));
    chk({tag, "_ovf_err"},  64'(ovf_err_o),  64'(0));
  endtask

  // Hold reset for two cycles, starting and ending on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    issue_i = 1'b0;
    m_ready_i = 1'b0;
    pipe_vld_i = 1'b0;
    pipe_data_i = '0;
    repeat (2) @(negedge clk);
    clearModel();
    rst_n = 1'b1;
    checkResetValues("rst");
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, update the model, advance.
  task automatic step(input bit iss, input logic [DW-1:0] idata, input bit rdy,
                      input bit frc, input logic [DW-1:0] fdata);
    bit            vld;
    bit            pop;
    bit            take;
    bit            wr;
    logic [DW-1:0] d;
    logic [DW-1:0] headDrop;
    op_t           opDrop;
    int            sum;
    vld = 1'b0;
    d = '0;
    if (invOn) begin
      sum = int'(count_o) + inflight.size() + int'(credits_o);
      chk("invariant", 64'(sum), 64'(DEP));
    end
    if (inflight.size() > 0 && inflight[0].arrive == cyc) begin
      vld = 1'b1;
      d = inflight[0].data;
      opDrop = inflight.pop_front();
    end
    if (frc) begin
      vld = 1'b1;
      d = fdata;
    end
    issue_i = iss;
    m_ready_i = rdy;
    pipe_vld_i = vld;
    pipe_data_i = d;

    chk("issue_ok", 64'(issue_ok_o), 64'(mCred != 0));
    chk("credits",  64'(credits_o),  64'(mCred));
    chk("count",    64'(count_o),    64'(mq.size()));
    chk("m_valid",  64'(m_valid_o),  64'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", m_data_o, mq[0]);
    chk("iss_err",  64'(iss_err_o),  64'(mIssErr));
    chk("ovf_err",  64'(ovf_err_o),  64'(mOvfErr));

    pop  = (mq.size() != 0) && rdy;
    take = iss && (mCred != 0);
    if (iss && mCred == 0) mIssErr = 1'b1;
    wr = vld && ((mq.size() < DEP) || pop);
    if (vld && !wr) mOvfErr = 1'b1;
    if (pop) begin
      headDrop = mq.pop_front();
      popCount++;
    end
    if (wr) mq.push_back(d);
    mCred = mCred - int'(take) + int'(pop);
    if (take) inflight.push_back('{arrive: cyc + LAT, data: idata});

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    popCount = 0;
    clearModel();
    @(negedge clk);
    doReset();

    // Idle after reset.
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0);

    // Burst of DEPTH issues with the consumer stalled, then let the pipeline empty.
    for (int i = 0; i < DEP; i++) step(1'b1, 64'(i), 1'b0, 1'b0, '0);
    chk("burst_credits_zero", 64'(credits_o), 64'(0));
    chk("burst_issue_ok_low", 64'(issue_ok_o), 64'(0));
    repeat (LAT) step(1'b0, '0, 1'b0, 1'b0, '0);
    chk("burst_count_full", 64'(count_o), 64'(DEP));
    chk("burst_head", m_data_o, 64'(0));

    // Issue with no credit: flagged, credits unchanged; one pop returns a credit.
    step(1'b1, 64'hDEAD, 1'b0, 1'b0, '0);
    chk("nocredit_iss_err", 64'(iss_err_o), 64'(1));
    chk("nocredit_credits", 64'(credits_o), 64'(0));
    step(1'b0, '0, 1'b1, 1'b0, '0);
    chk("pop_credit", 64'(credits_o), 64'(1));

    // Forced writes: refill, write+pop at full, then drop at full.
    invOn = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1, 64'h1000);
    chk("refill_count", 64'(count_o), 64'(DEP));
    step(1'b0, '0, 1'b1, 1'b1, 64'h1001);
    chk("full_wrpop_count", 64'(count_o), 64'(DEP));
    chk("full_wrpop_ovf", 64'(ovf_err_o), 64'(0));
    step(1'b0, '0, 1'b0, 1'b1, 64'h1002);
    chk("full_drop_ovf", 64'(ovf_err_o), 64'(1));
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0);
    chk("ovf_sticky", 64'(ovf_err_o), 64'(1));
    for (int i = 0; i < 40 && mq.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
    chk("drain_empty", 64'(m_valid_o), 64'(0));

    // Streaming: one issue per cycle with an always-ready consumer.
    doReset();
    popCount = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 30) chk("stream_credits_settle", 64'(credits_o), 64'(DEP - LAT - 1));
      step(1'b1, 64'(i), 1'b1, 1'b0, '0);
    end
    for (int i = 0; i < 40 && (mq.size() != 0 || inflight.size() != 0); i++)
      step(1'b0, '0, 1'b1, 1'b0, '0);
    chk("stream_pop_count", 64'(popCount), 64'(100));
    chk("stream_credits_back", 64'(credits_o), 64'(DEP));

    // Randomized traffic, including occasional issues without credit.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom % 4) != 0, 1'b0, '0);
    for (int i = 0; i < 60 && (mq.size() != 0 || inflight.size() != 0); i++)
      step(1'b0, '0, 1'b1, 1'b0, '0);
    chk("random_drained", 64'(count_o), 64'(0));

    // Mid-stream asynchronous reset with seven entries stored and more in flight.
    doReset();
    for (int i = 0; i < 7; i++) step(1'b1, 64'(i + 200), 1'b0, 1'b0, '0);
    repeat (LAT) step(1'b0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'(i + 300), 1'b0, 1'b0, '0);
    chk("midreset_count", 64'(count_o), 64'(7));
    rst_n = 1'b0;
    issue_i = 1'b0;
    pipe_vld_i = 1'b0;
    #1;
    checkResetValues("async");
    @(negedge clk);
    clearModel();
    rst_n = 1'b1;
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0);
    chk("after_release_credits", 64'(credits_o), 64'(DEP));
    chk("after_release_valid", 64'(m_valid_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
